// File: rtl/x9_mc_sequencer_pkg.sv
// Shared encodings for the x9 multi-cycle control path: opcodes, funct codes and sequencer states.
package x9_ctrl_def;

    typedef enum logic [2:0] {
        I_LW  = 3'b000,
        I_SW  = 3'b001,
        I_SET = 3'b010,
        R_ADD = 3'b011,
        R_SHF = 3'b100,
        R_NEG = 3'b101,
        B_BEQ = 3'b110,
        M_MOV = 3'b111
    } opcode_t;

    // funct codes overlap across opcodes; the opcode selects the meaning
    localparam logic [1:0] FUN_BEQ  = 2'b00;
    localparam logic [1:0] FUN_BNE  = 2'b01;
    localparam logic [1:0] FUN_BGT  = 2'b10;
    localparam logic [1:0] FUN_BLT  = 2'b11;
    localparam logic [1:0] FUN_LWR  = 2'b11;
    localparam logic [1:0] FUN_HALT = 2'b11;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/x9_mc_sequencer_sat_counter.sv
// Up-counter that clears on start and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         start,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (start) begin
            r_q <= '0;
        end else if (en && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/x9_mc_sequencer.sv
// Multi-cycle control sequencer for the x9 ISA: PC, instruction register, FSM,
// data-memory handshake with wait-state timeout, and saturating activity counters.
//
// state | meaning
// FETCH | latch instruction from ROM
// EXEC  | decode; resolve branches, dispatch to MEM or WB
// MEM   | hold mem_req until mem_ack or wait budget exhausted
// WB    | register-file write strobe, advance PC
// HALT  | frozen until start
module x9_mc_sequencer
    import x9_ctrl_def::*;
#(
    parameter int PC_W     = 16,
    parameter int IW       = 9,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             start,
    output logic [PC_W-1:0]  inst_addr,
    input  logic [IW-1:0]    inst_in,
    output logic [IW-1:0]    ir,
    input  logic             alu_zero,
    input  logic             alu_lsb,
    input  logic [PC_W-1:0]  branch_target,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             reg_we,
    output logic             halt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cycle_ct,
    output logic [CNT_W-1:0] instr_ct
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [IW-1:0]   r_ir;
    logic [WW-1:0]   r_wait;
    logic            r_timeout;
    logic            w_timeout;
    logic            w_retire;
    logic            w_taken;
    logic            w_cycle_en;
    opcode_t         w_op;
    logic [1:0]      w_funct;

    assign w_op     = opcode_t'(r_ir[IW-1:IW-3]);
    assign w_funct  = r_ir[1:0];
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        case (w_funct)
            FUN_BEQ: w_taken = alu_zero;
            FUN_BNE: w_taken = ~alu_zero;
            default: w_taken = alu_lsb;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            FETCH: w_state_nxt = EXEC;
            EXEC: begin
                case (w_op)
                    B_BEQ: begin
                        w_pc_nxt    = w_taken ? branch_target : w_pc_inc;
                        w_retire    = 1'b1;
                        w_state_nxt = FETCH;
                    end
                    R_NEG: begin
                        if (w_funct == FUN_HALT) begin
                            w_retire    = 1'b1;
                            w_state_nxt = HALT;
                        end else begin
                            w_state_nxt = WB;
                        end
                    end
                    I_LW, I_SW: w_state_nxt = MEM;
                    R_ADD:      w_state_nxt = (w_funct == FUN_LWR) ? MEM : WB;
                    default:    w_state_nxt = WB;
                endcase
            end
            MEM: begin
                // an ack in the last allowed cycle takes priority over the timeout
                if (mem_ack) begin
                    if (w_op == I_SW) begin
                        w_pc_nxt    = w_pc_inc;
                        w_retire    = 1'b1;
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = WB;
                    end
                end else if (r_wait == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = HALT;
                end
            end
            WB: begin
                w_pc_nxt    = w_pc_inc;
                w_retire    = 1'b1;
                w_state_nxt = FETCH;
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_state   <= FETCH;
            r_pc      <= PC_W'(RESET_PC);
            r_ir      <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (r_state == FETCH) begin
                r_ir <= inst_in;
            end
            // down-counter of remaining MEM cycles; zero marks the final one
            if (r_state == EXEC) begin
                r_wait <= WW'(MAX_WAIT - 1);
            end else if ((r_state == MEM) && (r_wait != '0)) begin
                r_wait <= r_wait - WW'(1);
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // the cycle that moves into HALT is not counted as an active cycle
    assign w_cycle_en = (r_state != HALT) && (w_state_nxt != HALT);

    sat_counter #(.W(CNT_W)) u_cycle_ct (
        .clk   (clk),
        .start (start),
        .en    (w_cycle_en),
        .q     (cycle_ct)
    );

    sat_counter #(.W(CNT_W)) u_instr_ct (
        .clk   (clk),
        .start (start),
        .en    (w_retire),
        .q     (instr_ct)
    );

    assign inst_addr   = r_pc;
    assign ir          = r_ir;
    assign mem_req     = (r_state == MEM);
    assign mem_we      = (r_state == MEM) && (w_op == I_SW);
    assign reg_we      = (r_state == WB);
    assign halt        = (r_state == HALT);
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_x9_mc_sequencer.sv
// Directed bench for x9_mc_sequencer: default-parameter instance plus a narrow
// PC_W=4 / CNT_W=4 instance for wrap and saturation.
module tb_x9_mc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        start;
    logic [15:0] inst_addr;
    logic [8:0]  inst_in;
    logic [8:0]  ir;
    logic        alu_zero, alu_lsb;
    logic [15:0] branch_target;
    logic        mem_req, mem_we, mem_ack, reg_we, halt, mem_timeout;
    logic [31:0] cycle_ct, instr_ct;

    logic [8:0]  rom [0:63];
    assign inst_in = rom[inst_addr[5:0]];

    x9_mc_sequencer dut (
        .clk           (clk),
        .start         (start),
        .inst_addr     (inst_addr),
        .inst_in       (inst_in),
        .ir            (ir),
        .alu_zero      (alu_zero),
        .alu_lsb       (alu_lsb),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_ack       (mem_ack),
        .reg_we        (reg_we),
        .halt          (halt),
        .mem_timeout   (mem_timeout),
        .cycle_ct      (cycle_ct),
        .instr_ct      (instr_ct)
    );

    logic        s_start;
    logic [3:0]  s_addr;
    logic [8:0]  s_ir;
    logic        s_mem_req, s_mem_we, s_reg_we, s_halt, s_timeout;
    logic [3:0]  s_cycle, s_instr;

    x9_mc_sequencer #(.PC_W(4), .CNT_W(4), .MAX_WAIT(3)) dut_s (
        .clk           (clk),
        .start         (s_start),
        .inst_addr     (s_addr),
        .inst_in       (9'h080),
        .ir            (s_ir),
        .alu_zero      (1'b0),
        .alu_lsb       (1'b0),
        .branch_target (4'h0),
        .mem_req       (s_mem_req),
        .mem_we        (s_mem_we),
        .mem_ack       (1'b0),
        .reg_we        (s_reg_we),
        .halt          (s_halt),
        .mem_timeout   (s_timeout),
        .cycle_ct      (s_cycle),
        .instr_ct      (s_instr)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 9'h143;
    endtask

    task automatic do_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        start = 1'b1; s_start = 1'b1; mem_ack = 1'b0;
        alu_zero = 1'b0; alu_lsb = 1'b0; branch_target = 16'h0020;

        // SET, ADD, HALT
        clear_rom();
        rom[0] = 9'h080; rom[1] = 9'h0C0; rom[2] = 9'h143;
        do_reset();
        check("rst_addr", inst_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_halt", halt, 0);
        check("rst_timeout", mem_timeout, 0);
        check("rst_cycle", cycle_ct, 0);
        check("rst_instr", instr_ct, 0);
        tick(2);
        check("set_we_c3", reg_we, 1);
        tick(1);
        check("we_c4", reg_we, 0);
        tick(2);
        check("add_we_c6", reg_we, 1);
        tick(3);
        check("prog_halt", halt, 1);
        check("prog_instr", instr_ct, 3);
        check("prog_cycle", cycle_ct, 7);
        check("prog_pc", inst_addr, 2);
        tick(4);
        check("halt_cycle_frozen", cycle_ct, 7);
        check("halt_ir_frozen", ir, 9'h143);
        check("halt_reg_we", reg_we, 0);

        // BEQ taken at PC=4
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = 9'h080;
        rom[4] = 9'h180;
        alu_zero = 1'b1;
        do_reset();
        tick(13);
        check("beq_ir", ir, 9'h180);
        check("beq_pc", inst_addr, 4);
        tick(1);
        check("beq_taken_pc", inst_addr, 16'h0020);
        check("beq_instr", instr_ct, 5);
        check("beq_cycle", cycle_ct, 14);

        // BEQ not taken
        alu_zero = 1'b0;
        do_reset();
        tick(14);
        check("beq_not_taken_pc", inst_addr, 5);

        // BGT taken on alu_lsb
        rom[4] = 9'h182;
        alu_lsb = 1'b1;
        do_reset();
        tick(14);
        check("bgt_taken_pc", inst_addr, 16'h0020);
        alu_lsb = 1'b0;

        // LW with three wait states; early ack in EXEC must be ignored
        clear_rom();
        rom[0] = 9'h000;
        do_reset();
        tick(1);
        mem_ack = 1'b1;
        check("lw_exec_req", mem_req, 0);
        tick(1);
        mem_ack = 1'b0;
        check("lw_req_c3", mem_req, 1);
        check("lw_we_c3", mem_we, 0);
        tick(2);
        check("lw_req_c5", mem_req, 1);
        tick(1);
        mem_ack = 1'b1;
        check("lw_req_c6", mem_req, 1);
        tick(1);
        mem_ack = 1'b0;
        check("lw_req_c7", mem_req, 0);
        check("lw_wb_c7", reg_we, 1);
        check("lw_instr_c7", instr_ct, 0);
        tick(1);
        check("lw_we_off", reg_we, 0);
        check("lw_retired", instr_ct, 1);
        check("lw_pc", inst_addr, 1);
        check("lw_cycle", cycle_ct, 7);

        // SW, no ack: timeout after 15 MEM cycles
        clear_rom();
        rom[0] = 9'h040;
        do_reset();
        tick(2);
        check("sw_req", mem_req, 1);
        check("sw_we", mem_we, 1);
        tick(14);
        check("sw_req_last", mem_req, 1);
        check("sw_no_halt_yet", halt, 0);
        check("sw_no_to_yet", mem_timeout, 0);
        tick(1);
        check("sw_timeout", mem_timeout, 1);
        check("sw_to_halt", halt, 1);
        check("sw_to_req", mem_req, 0);
        check("sw_to_instr", instr_ct, 0);
        mem_ack = 1'b1;
        tick(2);
        mem_ack = 1'b0;
        check("late_ack_halt", halt, 1);
        check("late_ack_instr", instr_ct, 0);
        check("late_ack_pc", inst_addr, 0);

        // SW ack in the final allowed cycle wins
        do_reset();
        check("rst_clears_to", mem_timeout, 0);
        tick(16);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        check("ack_last_halt", halt, 0);
        check("ack_last_to", mem_timeout, 0);
        check("ack_last_pc", inst_addr, 1);
        check("ack_last_instr", instr_ct, 1);

        // start mid-handshake on LWR
        clear_rom();
        rom[0] = 9'h0C3;
        do_reset();
        tick(3);
        check("mid_req", mem_req, 1);
        check("mid_ir", ir, 9'h0C3);
        check("mid_cycle", cycle_ct, 3);
        start = 1'b1;
        tick(1);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_pc", inst_addr, 0);
        check("mid_rst_cycle", cycle_ct, 0);
        check("mid_rst_ir", ir, 0);
        start = 1'b0;

        // narrow instance: PC wrap and counter saturation
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(45);
        check("s_pc15", s_addr, 15);
        check("s_cycle_sat", s_cycle, 15);
        check("s_instr15", s_instr, 15);
        tick(3);
        check("s_pc_wrap", s_addr, 0);
        check("s_instr_sat", s_instr, 15);
        check("s_cycle_hold", s_cycle, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
